// File: rtl/pipe_adder.sv
// Carry-pipelined adder: WIDTH bits split into STAGES slices with elastic valid/ready flow.
// Optional macro PIPE_ADDER_SUB_EN adds a 'sub' input that turns the operation into a - b.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int W    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers: full-width operand skew, partial sum and slice carry per stage
  logic [STAGES-1:0] v_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic [STAGES-1:0] c_r;
  logic              ovf_r;

  logic [STAGES:0]   ld_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              cin_eff_s;
  logic [STAGES-1:0] src_v_s;
  logic [WIDTH-1:0]  src_a_s [STAGES];
  logic [WIDTH-1:0]  src_b_s [STAGES];
  logic [WIDTH-1:0]  src_s_s [STAGES];
  logic [STAGES-1:0] src_c_s;
  logic [WIDTH-1:0]  nxt_s_s [STAGES];
  logic [STAGES-1:0] nxt_c_s;
  logic              ovf_nxt_s;

  // Effective operand B and carry-in (inverted B and forced carry for subtraction)
  always_comb begin
`ifdef PIPE_ADDER_SUB_EN
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = b;
      cin_eff_s = cin;
    end
`else
    b_eff_s   = b;
    cin_eff_s = cin;
`endif
  end

  // Load chain: a stage loads when empty or when its downstream neighbour loads
  always_comb begin : load_chain
    logic run;
    run          = out_ready;
    ld_s         = {(STAGES+1){1'b0}};
    ld_s[STAGES] = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      run     = !v_r[k] || run;
      ld_s[k] = run;
    end
  end

  // Per-stage upstream sources: ports feed stage 0, stage k-1 registers feed stage k
  always_comb begin
    src_v_s[0] = in_valid;
    src_a_s[0] = a;
    src_b_s[0] = b_eff_s;
    src_s_s[0] = {WIDTH{1'b0}};
    src_c_s[0] = cin_eff_s;
    for (int k = 1; k < STAGES; k++) begin
      src_v_s[k] = v_r[k-1];
      src_a_s[k] = a_r[k-1];
      src_b_s[k] = b_r[k-1];
      src_s_s[k] = s_r[k-1];
      src_c_s[k] = c_r[k-1];
    end
  end

  // Slice adders; the last stage also derives signed overflow from the MSBs
  always_comb begin : slice_add
    logic [W:0] t;
    t = {(W+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, src_a_s[k][k*W +: W]} + {1'b0, src_b_s[k][k*W +: W]}
          + {{W{1'b0}}, src_c_s[k]};
      nxt_s_s[k]            = src_s_s[k];
      nxt_s_s[k][k*W +: W]  = t[W-1:0];
      nxt_c_s[k]            = t[W];
    end
    ovf_nxt_s = (src_a_s[LAST][WIDTH-1] == src_b_s[LAST][WIDTH-1]) &&
                (nxt_s_s[LAST][WIDTH-1] != src_a_s[LAST][WIDTH-1]);
  end

  // Pipeline registers; a stage holds its contents whenever it does not load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r   <= {STAGES{1'b0}};
      c_r   <= {STAGES{1'b0}};
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        s_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld_s[k]) begin
          v_r[k] <= src_v_s[k];
          a_r[k] <= src_a_s[k];
          b_r[k] <= src_b_s[k];
          s_r[k] <= nxt_s_s[k];
          c_r[k] <= nxt_c_s[k];
        end
      end
      if (ld_s[LAST]) begin
        ovf_r <= ovf_nxt_s;
      end
    end
  end

  assign in_ready  = ld_s[0];
  assign out_valid = v_r[LAST];
  assign sum       = s_r[LAST];
  assign cout      = c_r[LAST];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=16, STAGES=4): directed table, stall stream, reset flush, random traffic.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin, in_valid, in_ready;
  logic [15:0] sum;
  logic        cout, ovf, out_valid, out_ready;
  logic        sub;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef PIPE_ADDER_SUB_EN
    , .sub(sub)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  logic [17:0] exp_q[$];
  logic [15:0] got_q[$];
  logic s_in_valid, s_in_ready, s_out_valid, s_cout, s_ovf;
  logic [15:0] s_sum;

  // Reference: unsigned sum for carry, signed integer sum for overflow; returns {cout, ovf, sum}
  function automatic logic [17:0] ref_add(logic [15:0] x, logic [15:0] y, logic ci, logic sb);
    int ux, uy, c, r, sx, sy, sr;
    logic [15:0] ye;
    ye = sb ? ~y : y;
    c  = (sb || ci) ? 1 : 0;
    ux = int'(x);
    uy = int'(ye);
    r  = ux + uy + c;
    sx = (ux >= 32768) ? ux - 65536 : ux;
    sy = (uy >= 32768) ? uy - 65536 : uy;
    sr = sx + sy + c;
    return {(r > 65535), (sr > 32767 || sr < -32768), r[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, expv);
    end
  endtask

  // One clock: sample at negedge, scoreboard transfers, then return at posedge+1
  task automatic tick();
    logic [17:0] e;
    @(negedge clk);
    s_in_valid  = in_valid;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_sum       = sum;
    s_cout      = cout;
    s_ovf       = ovf;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, cin, sub));
      if (out_valid && out_ready) begin
        got_q.push_back(sum);
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL scoreboard: unexpected result 0x%0h", sum);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard", {14'd0, cout, ovf, sum}, {14'd0, e});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    int lat, idx, stale;
    rst = 1'b1; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #2;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset sum/cout/ovf", {14'd0, cout, ovf, sum}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    rst = 1'b0;

    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0});
    tbl.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
    tbl.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
`ifdef PIPE_ADDER_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    tbl.push_back('{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0});
`endif

    // Directed vectors, one at a time, checking latency and result
    foreach (tbl[i]) begin
      a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("vec in_ready", {31'd0, s_in_ready}, 32'd1);
      in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
        tick();
        if (s_out_valid) begin lat = n; break; end
      end
      chk("vec latency", lat, 32'd4);
      chk("vec result", {14'd0, s_cout, s_ovf, s_sum}, {14'd0, tbl[i].co, tbl[i].ov, tbl[i].s});
    end
    sub = 1'b0;

    // Back-to-back stream with output stall in cycles 5..7
    got_q.delete();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (idx < 8);
      a = 16'(idx); b = 16'h0100; cin = 1'b0;
      tick();
      if (c >= 5 && c <= 7) chk("stream full in_ready", {31'd0, s_in_ready}, 32'd0);
      if (c < 5) chk("stream in_ready", {31'd0, s_in_ready}, 32'd1);
      if (s_in_valid && s_in_ready) idx++;
      if (idx == 8 && got_q.size() >= 8) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) chk("stream order", {16'd0, got_q[i]}, 32'h0100 + i);
    end

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a = 16'h0A00 + 16'(i); b = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst sum", {16'd0, sum}, 32'd0);
    tick();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_out_valid) stale++;
    end
    chk("midrst stale", stale, 32'd0);
    chk("midrst ready after", {31'd0, s_in_ready}, 32'd1);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
